// File: rtl/gpio_blink_mon_pkg.sv
// gpio_blink_mon_pkg
// Shared definitions for the GPIO blink monitor: the run-control FSM state
// encoding and the default widths used by the top and the channel slices.
// No ports.
// GPIO_BLINK_MON_DEGLITCH_EN (optional) enables the per-channel deglitch filter.

package gpio_blink_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_t;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_TO_W   = 24;
  localparam int DEF_DG_CYC = 4;

endpackage

// File: rtl/gpio_blink_chan.sv
// gpio_blink_chan
// One monitored pad: 2-flop synchronizer, optional deglitch filter, edge
// detect, "seen-high" flag and a saturating blink counter.
// Ports:
//   core_clk, core_rstn : clock, asynchronous active-low reset
//   gpio_in             : raw pad level (asynchronous)
//   run_en              : counting window (FSM in RUN)
//   clr                 : synchronous zeroing of counter and seen-high flag
//   target_count        : blinks required
//   blink_cnt           : saturating count of complete high-then-low pulses
//   reached             : blink_cnt >= target_count
// GPIO_BLINK_MON_DEGLITCH_EN defined: the synchronized level must hold a new
// value for DG_CYC consecutive cycles before it is passed on.

module gpio_blink_chan
  import gpio_blink_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W
`ifdef GPIO_BLINK_MON_DEGLITCH_EN
  ,
  parameter int DG_CYC = DEF_DG_CYC
`endif
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             gpio_in,
  input  logic             run_en,
  input  logic             clr,
  input  logic [CNT_W-1:0] target_count,
  output logic [CNT_W-1:0] blink_cnt,
  output logic             reached
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;
  logic       seen_high_q;
  logic       rise;
  logic       fall;

  // Two-flop synchronizer; sync_q[1] is the first metastability-safe sample.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], gpio_in};
    end
  end

`ifdef GPIO_BLINK_MON_DEGLITCH_EN
  localparam int DGW = $clog2(DG_CYC + 1);

  logic [DGW-1:0] dg_cnt_q;
  logic           filt_q;

  // The filtered level follows the synchronized level only after it has
  // disagreed for DG_CYC consecutive samples; any return to agreement
  // restarts the count, so shorter pulses vanish.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      dg_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      dg_cnt_q <= '0;
    end else if (dg_cnt_q == DGW'(DG_CYC - 1)) begin
      dg_cnt_q <= '0;
      filt_q   <= sync_q[1];
    end else begin
      dg_cnt_q <= dg_cnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  // prev tracks the level continuously so edges right at the start of a run
  // are judged against the true previous level.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  // A fall only counts once a rise has been observed in this run, so a pad
  // that is already high when the run starts does not yield a half pulse.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      seen_high_q <= 1'b0;
    end else if (clr) begin
      seen_high_q <= 1'b0;
    end else if (run_en && rise) begin
      seen_high_q <= 1'b1;
    end
  end

  // Saturating blink counter, active only inside the run window.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      blink_cnt <= '0;
    end else if (clr) begin
      blink_cnt <= '0;
    end else if (run_en && fall && seen_high_q && !(&blink_cnt)) begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign reached = (blink_cnt >= target_count);

endmodule

// File: rtl/gpio_blink_monitor.sv
// gpio_blink_monitor
// Multi-channel blink checker: counts complete high-then-low pulses on each
// pad and declares pass once the masked channels reach target_count, or fail
// on timeout / empty mask.
// Ports:
//   core_clk, core_rstn : clock, asynchronous active-low reset
//   gpio_in[N_CH]       : raw pad levels (asynchronous)
//   chan_mask[N_CH]     : channels that take part in the decision
//   start               : begin a run (IDLE only)
//   clear               : return to IDLE from any state, beats start
//   target_count        : blinks required per channel
//   timeout_cycles      : run length limit, 0 = unlimited
//   busy / pass / fail  : FSM in RUN / PASS / FAIL
//   blink_cnt           : per-channel counts, channel i at [i*CNT_W +: CNT_W]
// GPIO_BLINK_MON_DEGLITCH_EN defined: per-channel deglitch filter of DG_CYC
// cycles, adding DG_CYC cycles of latency.

module gpio_blink_monitor
  import gpio_blink_mon_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TO_W   = DEF_TO_W,
  parameter int ALL_CH = 1,
  parameter int DG_CYC = DEF_DG_CYC
) (
  input  logic                  core_clk,
  input  logic                  core_rstn,
  input  logic [N_CH-1:0]       gpio_in,
  input  logic [N_CH-1:0]       chan_mask,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CNT_W-1:0]      target_count,
  input  logic [TO_W-1:0]       timeout_cycles,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic [N_CH*CNT_W-1:0] blink_cnt
);

  mon_state_t      state_q;
  mon_state_t      state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [N_CH-1:0] reached;
  logic            run_en;
  logic            launch;
  logic            chan_clr;
  logic            any_hit;
  logic            all_hit;
  logic            reach;
  logic            timeout_hit;

  if (N_CH < 1 || N_CH > 38 || DG_CYC < 1) begin : g_bad_param
    $error("gpio_blink_monitor: N_CH must be 1..38 and DG_CYC at least 1");
  end

  assign run_en   = (state_q == RUN);
  assign launch   = start && !clear && (state_q == IDLE);
  assign chan_clr = clear || launch;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    gpio_blink_chan #(
      .CNT_W  (CNT_W)
`ifdef GPIO_BLINK_MON_DEGLITCH_EN
      ,
      .DG_CYC (DG_CYC)
`endif
    ) u_chan (
      .core_clk     (core_clk),
      .core_rstn    (core_rstn),
      .gpio_in      (gpio_in[i]),
      .run_en       (run_en),
      .clr          (chan_clr),
      .target_count (target_count),
      .blink_cnt    (blink_cnt[i*CNT_W +: CNT_W]),
      .reached      (reached[i])
    );
  end

  // Unmasked channels are forced true for the "all" reduction and false for
  // the "any" reduction; an empty mask never counts as reached.
  assign any_hit = |(reached & chan_mask);
  assign all_hit = (&(reached | ~chan_mask)) && (|chan_mask);
  assign reach   = (ALL_CH != 0) ? all_hit : any_hit;

  // The counter holds the number of completed RUN cycles, so comparing with
  // timeout_cycles-1 makes the FSM leave RUN exactly timeout_cycles edges
  // after entering it.
  assign timeout_hit = (timeout_cycles != '0) &&
                       (to_cnt_q == (timeout_cycles - TO_W'(1)));

  // Timeout counter: zeroed at launch/clear, saturating count of RUN cycles.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      to_cnt_q <= '0;
    end else if (chan_clr) begin
      to_cnt_q <= '0;
    end else if (run_en && !(&to_cnt_q)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore outputs. Reach is tested before timeout so that a
  // coincident reach wins; PASS and FAIL hold until clear.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    pass    = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (reach) begin
          state_d = PASS;
        end else if (chan_mask == '0) begin
          state_d = FAIL;
        end else if (timeout_hit) begin
          state_d = FAIL;
        end
      end
      PASS: pass = 1'b1;
      FAIL: fail = 1'b1;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

endmodule
